zeroriscy_irq_arbiter: RTL
==========================

ZERORISCY_IRQ_ARBITER -- requirements
Module: zeroriscy_irq_arbiter

Interface
REQ-001 SHALL have parameter: N_IRQ, 32, number of interrupt source lines (legal range 1..32).
REQ-002 SHALL have ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_i  input  N_IRQ  interrupt source lines, already synchronous to clk.
- cfg_we_i  input  1  configuration write strobe.
- cfg_addr_i  input  2  register select: 0 = ENABLE, 1 = EDGE, 2 = PENDING, 3 = STATUS.
- cfg_wdata_i  input  32  write data.
- cfg_rdata_o  output  32  read data, combinational from cfg_addr_i.
- irq_o  output  1  request to the core interrupt controller.
- irq_id_o  output  5  ID of the offered interrupt.
- irq_ack_i  input  1  core accepted the offered interrupt.
- irq_kill_i  input  1  core dropped the offered interrupt before acceptance.
- eoi_i  input  1  end of interrupt (mret retired).

Function
REQ-003 SHALL treat ENABLE as a per-line mask; a line with ENABLE = 0 is never offered.
REQ-004 SHALL set line mode per EDGE bit: 0 = level-sensitive, 1 = rising-edge-sensitive.
REQ-005 SHALL register src_i every cycle as src_q; a rising edge on line k is src_i[k] & ~src_q[k].
REQ-006 SHALL set PENDING[k] one cycle after a rising edge on an edge-mode line k, regardless of ENABLE.
REQ-007 SHALL define active[k] as ENABLE[k] & (EDGE[k] ? PENDING[k] : src_i[k]).
REQ-008 SHALL arbitrate with fixed priority, lowest index wins.
REQ-009 SHALL implement FSM states IDLE, OFFER, CLAIMED; outputs:
- irq_o = 1 only in OFFER.
- irq_id_o = registered locked ID in every state.
REQ-010 SHALL perform IDLE -> OFFER when any active bit is set, locking the winning ID in the same cycle; irq_o rises one cycle after the first active condition.
REQ-011 SHALL hold irq_id_o constant in OFFER, even if a higher-priority line becomes active; no preemption.
REQ-012 SHALL apply OFFER priority rule ack > kill > withdraw > stay:
- irq_ack_i -> CLAIMED.
- irq_kill_i -> IDLE.
- locked line no longer active (level line dropped, or ENABLE cleared) -> IDLE.
- otherwise stay in OFFER.
REQ-013 SHALL clear PENDING[locked ID] on the ack cycle if that line is in edge mode; a new edge on the same line in the same cycle SHALL win and leave the bit set.
REQ-014 SHALL stay in CLAIMED until eoi_i, then go to IDLE; irq_ack_i and irq_kill_i SHALL be ignored outside OFFER, and eoi_i SHALL be ignored outside CLAIMED.
REQ-015 SHALL allow re-offer no earlier than the cycle after returning to IDLE; minimum gap between offers is 1 IDLE cycle.
REQ-016 SHALL handle configuration writes:
- ENABLE and EDGE: full overwrite.
- PENDING: write-1-to-clear.
- STATUS: read-only (write ignored).
REQ-017 SHALL resolve a PENDING W1C in the same cycle as a new edge in favour of the edge (bit remains 1).
REQ-018 SHALL return on STATUS read: bit0 = irq_o, bit1 = (state == CLAIMED), bits[12:8] = irq_id_o, other bits 0.
REQ-019 SHALL return 0 for all bits at index >= N_IRQ in ENABLE/EDGE/PENDING reads, and SHALL not store those bits.
REQ-020 SHALL apply configuration writes from the cycle after cfg_we_i, including arbitration.

Reset
REQ-021 SHALL, on rst_n low, asynchronously set:
- state = IDLE; irq_o = 0; irq_id_o = 0.
- ENABLE = 0, EDGE = 0, PENDING = 0, src_q = 0.
REQ-022 SHALL, after reset, sample no edges until the first rising clk edge with rst_n high; a line already high at reset release SHALL count as a rising edge.
REQ-023 SHALL, when reset is applied mid-OFFER or mid-CLAIMED, abandon the interrupt with no ack/eoi required.

Verification
REQ-024 Level priority: ENABLE = 0x0000_00FF; src_i = 0x0000_0024 held -> irq_o = 1 with irq_id_o = 2 one cycle later; ack -> CLAIMED; eoi -> IDLE; re-offer ID 2 one IDLE cycle later.
REQ-025 Edge latch: EDGE[5] = 1, ENABLE[5] = 1; 1-cycle pulse on src_i[5] -> PENDING = 0x20; offer ID 5; ack clears PENDING to 0.
REQ-026 No preemption: offering ID 7, then src_i[1] rises -> irq_id_o stays 7 until ack; after eoi, ID 1 is offered next.
REQ-027 Kill/withdraw: in OFFER, assert irq_kill_i -> IDLE, then re-offer; in OFFER, drop level line -> irq_o = 0 next cycle.
REQ-028 Collisions: W1C PENDING[3] in the same cycle as a new edge on line 3 -> PENDING[3] stays 1; ack plus a new edge on the locked line in the same cycle -> bit stays 1.
REQ-029 Reset mid-CLAIMED -> all outputs 0 immediately; a line held high through reset release is sampled as an edge when EDGE = 1.

Source files
------------

// File: rtl/zeroriscy_irq_arbiter.sv
// ---------------------------------------------------------------------------
// zeroriscy_irq_arbiter
//
// Fixed-priority interrupt arbiter placed in front of the core interrupt
// controller. Each source line can be masked (ENABLE) and configured as
// level- or rising-edge-sensitive (EDGE). Edges are latched in PENDING.
//
// The lowest-indexed active line is offered to the core. Once offered, the ID
// is locked until the core acknowledges it, kills it, or the line withdraws.
// After an acknowledge, the arbiter waits for end-of-interrupt before it
// offers anything new.
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   src_i         interrupt source lines, already synchronous to clk
//   cfg_we_i      configuration write strobe
//   cfg_addr_i    register select: 0 ENABLE, 1 EDGE, 2 PENDING (W1C), 3 STATUS (RO)
//   cfg_wdata_i   configuration write data
//   cfg_rdata_o   configuration read data, combinational from cfg_addr_i
//   irq_o         interrupt offered to the core
//   irq_id_o      ID of the offered (most recently locked) interrupt
//   irq_ack_i     core accepted the offered interrupt
//   irq_kill_i    core dropped the offered interrupt before accepting it
//   eoi_i         end of interrupt (mret retired)
// ---------------------------------------------------------------------------
module zeroriscy_irq_arbiter #(
  parameter int N_IRQ = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] src_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  output logic             irq_o,
  output logic [4:0]       irq_id_o,
  input  logic             irq_ack_i,
  input  logic             irq_kill_i,
  input  logic             eoi_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    CLAIMED = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // Configuration and line state
  logic [N_IRQ-1:0] enable_q;
  logic [N_IRQ-1:0] edge_q;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] pending_d;
  logic [N_IRQ-1:0] src_q;

  // Derived line vectors
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] clr_mask;
  logic [31:0]      active_ext;
  logic [31:0]      locked_onehot;
  logic             any_active;
  logic [4:0]       win_id;

  // Arbitration FSM
  state_e     state_q;
  state_e     state_d;
  logic [4:0] id_q;
  logic [4:0] id_d;
  logic       ack_clear;

  // -------------------------------------------------------------------------
  // Edge detection and active vector
  // -------------------------------------------------------------------------
  always_comb begin
    rise       = src_i & ~src_q;
    active     = enable_q & ((edge_q & pending_q) | (~edge_q & src_i));
    any_active = |active;
    // Widened copies let a 5-bit ID index safely even when N_IRQ < 32.
    active_ext    = 32'(active);
    locked_onehot = 32'd1 << id_q;
  end

  // Fixed priority: scanning downwards leaves the lowest active index.
  always_comb begin
    win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) win_id = 5'(i);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ack_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_active) begin
          state_d = OFFER;
          id_d    = win_id;
        end
      end
      OFFER: begin
        // The locked ID is held; a newly active higher-priority line waits.
        if (irq_ack_i) begin
          state_d   = CLAIMED;
          ack_clear = 1'b1;
        end else if (irq_kill_i) begin
          state_d = IDLE;
        end else if (!active_ext[id_q]) begin
          state_d = IDLE;
        end
      end
      CLAIMED: begin
        if (eoi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // PENDING: W1C and ack clears lose against a same-cycle new edge, and edges
  // are latched whether or not the line is enabled.
  always_comb begin
    clr_mask = '0;
    if (cfg_we_i && cfg_addr_i == ADDR_PENDING) clr_mask = clr_mask | cfg_wdata_i[N_IRQ-1:0];
    if (ack_clear) clr_mask = clr_mask | (locked_onehot[N_IRQ-1:0] & edge_q);
    pending_d = (pending_q & ~clr_mask) | (rise & edge_q);
  end

  // -------------------------------------------------------------------------
  // State registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      src_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      src_q     <= src_i;
      if (cfg_we_i && cfg_addr_i == ADDR_ENABLE) enable_q <= cfg_wdata_i[N_IRQ-1:0];
      if (cfg_we_i && cfg_addr_i == ADDR_EDGE)   edge_q   <= cfg_wdata_i[N_IRQ-1:0];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign irq_o    = (state_q == OFFER);
  assign irq_id_o = id_q;

  always_comb begin
    cfg_rdata_o = '0;
    unique case (cfg_addr_i)
      ADDR_ENABLE:  cfg_rdata_o = 32'(enable_q);
      ADDR_EDGE:    cfg_rdata_o = 32'(edge_q);
      ADDR_PENDING: cfg_rdata_o = 32'(pending_q);
      ADDR_STATUS:  cfg_rdata_o = {19'd0, irq_id_o, 6'd0, (state_q == CLAIMED), irq_o};
      default:      cfg_rdata_o = '0;
    endcase
  end

endmodule
